alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one Alu instance (32-bit a/b, 3-bit op, unsig; outputs aluout, compout, overflow) between two requesters, e.g. an integer-execute port and a branch/compare port.
- Arbitration is round-robin with a valid/ready request handshake.
- Operands are registered before the Alu, and results are registered after it with a requester id.
- A saturating counter records Alu overflows for debug and status reads.

Parameters:
- CNT_W, 16, width of the saturating overflow event counter.
- INIT_PRIO, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: operation i is accepted this cycle.
- req_a  input  64  operand a; requester i in [32i+31:32i].
- req_b  input  64  operand b; same slicing as req_a.
- req_op  input  6  Alu op; requester i in [3i+2:3i].
- req_unsig  input  2  Alu unsig flag per requester.
- rsp_valid  output  1  result registers hold a valid response.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that issued the response.
- rsp_aluout  output  32  registered Alu aluout.
- rsp_compout  output  1  registered Alu compout.
- rsp_overflow  output  1  registered Alu overflow.
- busy  output  1  state is not IDLE.
- ovf_count  output  CNT_W  count of responses with overflow=1; saturates at all-ones.
- ovf_clear  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, prio=INIT_PRIO.
  - Zeroed: rsp_valid, rsp_id, rsp_aluout, rsp_compout, rsp_overflow, ovf_count, all operand registers.
  - req_ready=0 while reset is high.
  - Reset mid-operation discards the in-flight operation and any pending response.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. It asserts only in IDLE, for at most one bit.
  - Grant rule: if both requests are valid, grant prio. Otherwise grant whichever is valid.
  - On grant: latch a, b, op, unsig and the id into operand registers, go to EXEC.
  - The rotation updates prio to the non-granted requester.
  - With no request: stay in IDLE and keep prio.
- EXEC:
  - The Alu is driven only from the operand registers.
  - At the clock edge, capture aluout, compout and overflow into the rsp_* registers, set rsp_valid=1, go to RESP.
  - The ALU evaluation is one cycle and is purely combinational inside.
- RESP:
  - rsp_* values are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: clear rsp_valid, go to IDLE. A new grant is possible the following cycle.
  - No bypass: a grant cannot occur in the same cycle the response drains.
- Latency: request accepted in cycle N gives rsp_valid=1 in cycle N+2. Throughput is one operation per 3 cycles when rsp_ready is tied high.
- Request inputs are ignored outside IDLE. A requester keeps valid high until it sees its ready bit.
- ovf_count:
  - Increments by 1 in the cycle the EXEC→RESP capture has overflow=1.
  - Saturates at 2^CNT_W-1.
  - ovf_clear has priority over an increment in the same cycle (result 0).
- Op codes and unsig are passed to the Alu unmodified. There is no decode or validation in this block.
- busy = (state != IDLE).

Decomposition:
- Shared package alu_pkg:
  - Alu op encodings: AND=000, OR=001, ADD=010, NOR=100, XOR=101, SUB=110.
  - FSM state encoding: IDLE, EXEC, RESP.
  - Data width constant 32.
- One sub-module: the existing Alu, instantiated once inside alu_arbiter. The arbiter logic, FSM and counter stay in the top.

Test Plan:
- Single request: requester 0 sends AND, a=0x43667107, b=0x0CC64678.
  - req_ready[0]=1 at cycle N.
  - At N+2: rsp_valid=1, rsp_id=0, rsp_aluout=0x00464000, overflow=0.
- Contention: both requesters valid from reset (INIT_PRIO=0), r0 OR, r1 ADD on the same operands, rsp_ready=1.
  - First response: id=0, aluout=0x4FE6777F.
  - Second response: id=1, aluout=0x502CB77F.
  - Grants alternate 0,1,0,1 under continuous contention.
- Overflow: ADD, a=b=0x7FFFFFFF, unsig=0.
  - rsp_aluout=0xFFFFFFFE, rsp_overflow=1, ovf_count increments 0→1.
  - ovf_clear in the same cycle as a second overflow capture leaves ovf_count=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_* stay stable and req_ready=00 throughout.
  - rsp_ready=1 returns the FSM to IDLE the next cycle.
- Reset mid-op: assert reset asynchronously during EXEC.
  - All outputs go 0 immediately and prio=INIT_PRIO.
  - After release, a new request completes normally with the correct result.
- Saturation: force CNT_W=4 and run 20 overflowing ADDs → ovf_count stays at 0xF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared Alu definitions: data width, op encodings and arbiter FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DATA_W = 32;

  // Alu op encodings; 011 and 111 are unused and produce zero.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// 32-bit Alu: logic ops, add/sub with signed overflow, and a less-than compare.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b operands; op selects the function; unsig selects unsigned
//        compare and suppresses signed overflow; aluout, compout, overflow results.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  input  logic              unsig,
  output logic [DATA_W-1:0] aluout,
  output logic              compout,
  output logic              overflow
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    aluout   = '0;
    overflow = 1'b0;
    case (op)
      OP_AND: aluout = a & b;
      OP_OR:  aluout = a | b;
      OP_NOR: aluout = ~(a | b);
      OP_XOR: aluout = a ^ b;
      OP_ADD: begin
        aluout   = sum;
        // same-sign operands producing a result of the other sign
        overflow = !unsig && (a[DATA_W-1] == b[DATA_W-1]) &&
                   (sum[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        aluout   = diff;
        overflow = !unsig && (a[DATA_W-1] != b[DATA_W-1]) &&
                   (diff[DATA_W-1] != a[DATA_W-1]);
      end
      default: aluout = '0;
    endcase
  end

  // Compare is evaluated for every op; consumers pick it up as needed.
  assign compout = unsig ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one Alu between two requesters, with overflow event counter.
// Latency: request accepted in cycle N -> rsp_valid in cycle N+2; one op per 3 cycles max.
// Backpressure: response held until rsp_ready; req_ready low whenever not IDLE.
// Ports: clk/reset; req_valid/req_ready/req_a/req_b/req_op/req_unsig per-requester
//        request lanes; rsp_* registered result with id; busy; ovf_count/ovf_clear.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int INIT_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [5:0]          req_op,
  input  logic [1:0]          req_unsig,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_aluout,
  output logic                rsp_compout,
  output logic                rsp_overflow,
  output logic                busy,
  output logic [CNT_W-1:0]    ovf_count,
  input  logic                ovf_clear
);

  localparam logic PRIO_RST = (INIT_PRIO != 0);

  state_t            state;
  logic              prio;
  logic [1:0]        grant;
  logic              gnt_id;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [2:0]        op_q;
  logic              unsig_q;
  logic              id_q;
  logic [DATA_W-1:0] alu_out;
  logic              alu_comp;
  logic              alu_ovf;

  // Grant only in IDLE; ties go to prio, otherwise the sole valid requester wins.
  always_comb begin
    grant = 2'b00;
    if (!reset && state == IDLE) begin
      if (req_valid == 2'b11) grant[prio] = 1'b1;
      else                    grant       = req_valid;
    end
  end

  assign req_ready = grant;
  assign gnt_id    = grant[1];
  assign busy      = (state != IDLE);

  alu u_alu (
    .a        (opa_q),
    .b        (opb_q),
    .op       (op_q),
    .unsig    (unsig_q),
    .aluout   (alu_out),
    .compout  (alu_comp),
    .overflow (alu_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= PRIO_RST;
      opa_q        <= '0;
      opb_q        <= '0;
      op_q         <= '0;
      unsig_q      <= 1'b0;
      id_q         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_aluout   <= '0;
      rsp_compout  <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            opa_q   <= gnt_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            opb_q   <= gnt_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            op_q    <= gnt_id ? req_op[5:3] : req_op[2:0];
            unsig_q <= req_unsig[gnt_id];
            id_q    <= gnt_id;
            // Rotate so the requester that lost this round wins the next tie.
            prio    <= ~gnt_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid    <= 1'b1;
          rsp_id       <= id_q;
          rsp_aluout   <= alu_out;
          rsp_compout  <= alu_comp;
          rsp_overflow <= alu_ovf;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow events are counted at the EXEC->RESP capture; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (state == EXEC && alu_ovf && ovf_count != {CNT_W{1'b1}}) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule
